alu_share_arbiter: RTL and testbench

Two-requester round-robin controller that time-shares a single combinational ALU instance (4-bit `alu_ctr`, N/Z/C/V flags) between two clients, e.g. the integer pipeline and a debug/test port. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and control inputs from internal registers. It captures the ALU result and flags one cycle later and returns them to the granted client over a valid/ready response channel. The ALU itself stays outside this block; this block only sequences it.

---
 rtl/alu_share_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_share_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sequencer sharing one external ALU between two clients
module alu_share_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  input  logic [3:0]   req_ctr0,
  input  logic [3:0]   req_ctr1,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [W-1:0] rsp_data,
  output logic [3:0]   rsp_flags,
  output logic         rsp_err,
  output logic [W-1:0] alu_i1,
  output logic [W-1:0] alu_i2,
  output logic [3:0]   alu_ctr,
  input  logic [W-1:0] alu_out,
  input  logic         alu_n,
  input  logic         alu_z,
  input  logic         alu_c,
  input  logic         alu_v,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic           last_grant_q;
  logic           owner_q;
  logic [W-1:0]   a_q, b_q;
  logic [3:0]     ctr_q;
  logic [W-1:0]   data_q;
  logic [3:0]     flags_q;
  logic           err_q;

  logic           grant;
  logic           accept;
  logic [W-1:0]   sel_a, sel_b;
  logic [3:0]     sel_ctr;

  // Pick the winner: a lone requester, or on a tie the client not served last.
  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) begin
      grant = ~last_grant_q;
    end else if (req_valid[1]) begin
      grant = 1'b1;
    end
  end

  // Operand mux for the granted client.
  always_comb begin
    sel_a   = grant ? req_a1   : req_a0;
    sel_b   = grant ? req_b1   : req_b0;
    sel_ctr = grant ? req_ctr1 : req_ctr0;
  end

  // Next-state and handshake outputs; one op in flight, so ready only in IDLE.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    accept    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_d          = EXEC;
        end
      end
      EXEC: begin
        state_d = RESP;
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; last_grant resets to 1 so client 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q      <= grant;
        last_grant_q <= grant;
      end
    end
  end

  // Operand registers feed the ALU in every state, never req_* directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      ctr_q <= 4'b0000;
    end else if (accept) begin
      a_q   <= sel_a;
      b_q   <= sel_b;
      ctr_q <= sel_ctr;
    end
  end

  // Capture the ALU result at the end of EXEC; held until the next EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      flags_q <= 4'b0000;
      err_q   <= 1'b0;
    end else if (state_q == EXEC) begin
      data_q  <= alu_out;
      flags_q <= {alu_n, alu_z, alu_c, alu_v};
      err_q   <= (ctr_q > 4'b1001);
    end
  end

  assign alu_i1    = a_q;
  assign alu_i2    = b_q;
  assign alu_ctr   = ctr_q;
  assign rsp_data  = data_q;
  assign rsp_flags = flags_q;
  assign rsp_err   = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - scoreboard bench for alu_share_arbiter with a behavioural ALU
module tb_alu_share_arbiter;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [W-1:0] req_a0, req_b0, req_a1, req_b1;
  logic [3:0]   req_ctr0, req_ctr1;
  logic [1:0]   rsp_valid;
  logic [1:0]   rsp_ready;
  logic [W-1:0] rsp_data;
  logic [3:0]   rsp_flags;
  logic         rsp_err;
  logic [W-1:0] alu_i1, alu_i2;
  logic [3:0]   alu_ctr;
  logic [W-1:0] alu_out;
  logic         alu_n, alu_z, alu_c, alu_v;
  logic         busy;

  typedef struct {
    logic         cl;
    logic [W-1:0] d;
    logic [3:0]   f;
    logic         e;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   ctr;
  } op_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  alu_share_arbiter #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_ctr0(req_ctr0), .req_ctr1(req_ctr1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err),
    .alu_i1(alu_i1), .alu_i2(alu_i2), .alu_ctr(alu_ctr),
    .alu_out(alu_out), .alu_n(alu_n), .alu_z(alu_z), .alu_c(alu_c), .alu_v(alu_v),
    .busy(busy)
  );

  // Reference ALU: {out, N, Z, C, V}; codes above 1001 return 0 with Z=1.
  function automatic logic [W+3:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [3:0] ctr);
    logic [W:0]   s;
    logic [W-1:0] o;
    logic         c, v;
    s = '0; o = '0; c = 1'b0; v = 1'b0;
    case (ctr)
      4'd0: o = a & b;
      4'd1: o = a | b;
      4'd2: begin
        s = {1'b0, a} + {1'b0, b}; o = s[W-1:0]; c = s[W];
        v = (a[W-1] == b[W-1]) && (o[W-1] != a[W-1]);
      end
      4'd3: begin
        s = {1'b0, a} - {1'b0, b}; o = s[W-1:0]; c = s[W];
        v = (a[W-1] != b[W-1]) && (o[W-1] != a[W-1]);
      end
      4'd4: o = a ^ b;
      4'd5: o = ~(a | b);
      4'd6: o = a << b[4:0];
      4'd7: o = a >> b[4:0];
      4'd8: o = ~a;
      4'd9: o = b;
      default: o = '0;
    endcase
    return {o, o[W-1], (o == '0), c, v};
  endfunction

  assign {alu_out, alu_n, alu_z, alu_c, alu_v} = alu_f(alu_i1, alu_i2, alu_ctr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [1:0] oh(input int c);
    return (c != 0) ? 2'b10 : 2'b01;
  endfunction

  function automatic exp_t mk_exp(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] ctr);
    exp_t         e;
    logic [W+3:0] r;
    r    = alu_f(a, b, ctr);
    e.cl = (c != 0);
    e.d  = r[W+3:4];
    e.f  = r[3:0];
    e.e  = (ctr > 4'b1001);
    return e;
  endfunction

  // Response monitor: every completed response handshake pops the scoreboard.
  always @(negedge clk) begin : rsp_mon
    exp_t e;
    if (rst_n && |(rsp_valid & rsp_ready)) begin
      if (sb.size() == 0) begin
        check_eq("rsp_unexpected", 64'(rsp_valid), 64'(2'b00));
      end else begin
        e = sb.pop_front();
        check_eq("rsp_client", 64'(rsp_valid), 64'(oh(int'(e.cl))));
        check_eq("rsp_data",   64'(rsp_data),  64'(e.d));
        check_eq("rsp_flags",  64'(rsp_flags), 64'(e.f));
        check_eq("rsp_err",    64'(rsp_err),   64'(e.e));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (|req_ready) break;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 30; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    check_eq("drain", 64'(sb.size()), 64'(0));
  endtask

  task automatic load(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [3:0] ctr);
    if (c == 0) begin req_a0 = a; req_b0 = b; req_ctr0 = ctr; end
    else        begin req_a1 = a; req_b1 = b; req_ctr1 = ctr; end
  endtask

  // Issue one op, check the EXEC cycle and that the response appears two edges after accept.
  task automatic issue(input int c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] ctr);
    load(c, a, b, ctr);
    req_valid[c] = 1'b1;
    wait_grant();
    check_eq("grant", 64'(req_ready), 64'(oh(c)));
    sb.push_back(mk_exp(c, a, b, ctr));
    step();
    req_valid[c] = 1'b0;
    @(negedge clk);
    check_eq("exec_busy",      64'(busy),      64'(1));
    check_eq("exec_rsp_valid", 64'(rsp_valid), 64'(2'b00));
    check_eq("exec_alu_i1",    64'(alu_i1),    64'(a));
    check_eq("exec_alu_i2",    64'(alu_i2),    64'(b));
    check_eq("exec_alu_ctr",   64'(alu_ctr),   64'(ctr));
    @(negedge clk);
    check_eq("latency_rsp_valid", 64'(rsp_valid), 64'(oh(c)));
  endtask

  initial begin
    op_t ops0[2];
    op_t ops1[2];
    int  idx0, idx1;

    ops0[0] = '{32'd10, 32'd20, 4'd2};
    ops0[1] = '{32'd9, 32'd4, 4'd3};
    ops1[0] = '{32'hF0, 32'h3C, 4'd0};
    ops1[1] = '{32'd1, 32'd31, 4'd6};
    idx0 = 0; idx1 = 0;

    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    load(0, ops0[0].a, ops0[0].b, ops0[0].ctr);
    load(1, ops1[0].a, ops1[0].b, ops1[0].ctr);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req_ready", 64'(req_ready), 64'(2'b00));
    check_eq("rst_rsp_valid", 64'(rsp_valid), 64'(2'b00));
    check_eq("rst_busy",      64'(busy),      64'(0));
    check_eq("rst_rsp_data",  64'(rsp_data),  64'(0));
    check_eq("rst_rsp_flags", 64'(rsp_flags), 64'(0));
    check_eq("rst_rsp_err",   64'(rsp_err),   64'(0));
    check_eq("rst_alu_i1",    64'(alu_i1),    64'(0));
    check_eq("rst_alu_ctr",   64'(alu_ctr),   64'(0));

    // Contention from reset: grants must alternate 0,1,0,1.
    step();
    rst_n = 1'b1; rsp_ready = 2'b11; req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = k % 2;
      wait_grant();
      check_eq("cont_grant", 64'(req_ready), 64'(oh(c)));
      if (c == 0) sb.push_back(mk_exp(0, req_a0, req_b0, req_ctr0));
      else        sb.push_back(mk_exp(1, req_a1, req_b1, req_ctr1));
      step();
      if (c == 0) begin
        idx0++;
        if (idx0 < 2) load(0, ops0[idx0].a, ops0[idx0].b, ops0[idx0].ctr);
        else req_valid[0] = 1'b0;
      end else begin
        idx1++;
        if (idx1 < 2) load(1, ops1[idx1].a, ops1[idx1].b, ops1[idx1].ctr);
        else req_valid[1] = 1'b0;
      end
    end
    drain();

    // Client 0 ADD.
    step();
    issue(0, 32'd5, 32'd3, 4'b0010);
    check_eq("add0_data",  64'(rsp_data),  64'(32'd8));
    check_eq("add0_flags", 64'(rsp_flags), 64'(4'b0000));
    check_eq("add0_err",   64'(rsp_err),   64'(0));
    drain();

    // Client 1 ADD with carry out.
    step();
    issue(1, 32'hFFFF_FFFF, 32'd1, 4'b0010);
    check_eq("add1_data",  64'(rsp_data),  64'(32'd0));
    check_eq("add1_flags", 64'(rsp_flags), 64'(4'b0110));
    drain();

    // Backpressure on client 0 with client 1 pending; non-owner ready is ignored.
    step();
    rsp_ready = 2'b10;
    load(1, 32'd100, 32'd58, 4'd3);
    req_valid[1] = 1'b1;
    issue(0, 32'h1234, 32'h0F0F, 4'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_rsp_valid", 64'(rsp_valid), 64'(2'b01));
      check_eq("bp_rsp_data",  64'(rsp_data),  64'(32'h1F3F));
      check_eq("bp_rsp_flags", 64'(rsp_flags), 64'(4'b0000));
      check_eq("bp_req_ready", 64'(req_ready), 64'(2'b00));
    end
    step();
    rsp_ready = 2'b11;
    @(negedge clk);
    check_eq("bp_hs_req_ready", 64'(req_ready), 64'(2'b00));
    @(negedge clk);
    check_eq("bp_next_grant", 64'(req_ready), 64'(2'b10));
    sb.push_back(mk_exp(1, 32'd100, 32'd58, 4'd3));
    step();
    req_valid[1] = 1'b0;
    drain();

    // Illegal op passes through with rsp_err; the next legal op clears it.
    step();
    issue(0, 32'd7, 32'd2, 4'b1100);
    check_eq("ill_data",  64'(rsp_data),  64'(32'd0));
    check_eq("ill_flags", 64'(rsp_flags), 64'(4'b0100));
    check_eq("ill_err",   64'(rsp_err),   64'(1));
    drain();
    step();
    issue(1, 32'd6, 32'd7, 4'd4);
    check_eq("legal_data", 64'(rsp_data), 64'(32'd1));
    check_eq("legal_err",  64'(rsp_err),  64'(0));
    drain();

    // Asynchronous reset during EXEC drops the op.
    step();
    load(0, 32'd3, 32'd4, 4'd2);
    req_valid = 2'b01;
    wait_grant();
    check_eq("ar_grant", 64'(req_ready), 64'(2'b01));
    step();
    #1;
    rst_n = 1'b0;
    req_valid = 2'b00;
    #1;
    check_eq("ar_busy",      64'(busy),      64'(0));
    check_eq("ar_rsp_valid", 64'(rsp_valid), 64'(2'b00));
    check_eq("ar_req_ready", 64'(req_ready), 64'(2'b00));
    check_eq("ar_rsp_data",  64'(rsp_data),  64'(0));
    check_eq("ar_rsp_flags", 64'(rsp_flags), 64'(0));
    check_eq("ar_alu_i1",    64'(alu_i1),    64'(0));
    check_eq("ar_alu_ctr",   64'(alu_ctr),   64'(0));
    repeat (2) @(posedge clk);
    #1;
    load(0, 32'd11, 32'd22, 4'd1);
    load(1, 32'd8, 32'd2, 4'd7);
    req_valid = 2'b11;
    rst_n = 1'b1;
    wait_grant();
    check_eq("ar_tie_grant", 64'(req_ready), 64'(2'b01));
    sb.push_back(mk_exp(0, 32'd11, 32'd22, 4'd1));
    step();
    req_valid[0] = 1'b0;
    wait_grant();
    check_eq("ar_second_grant", 64'(req_ready), 64'(2'b10));
    sb.push_back(mk_exp(1, 32'd8, 32'd2, 4'd7));
    step();
    req_valid[1] = 1'b0;
    drain();

    repeat (3) @(negedge clk);
    check_eq("sb_final", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
